// File: rtl/medidor_frecuencia_pkg.sv
// Shared types and helpers for the frequency meter.
// State encodings, BCD digit width and the digit step function.
package medidor_frecuencia_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } estado_t;

  function automatic logic [DIGIT_W-1:0] bcd_next(
    input logic [DIGIT_W-1:0] d,
    input logic               inc
  );
    if (!inc) return d;
    return (d == BCD_MAX) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/contador_bcd.sv
// One BCD digit with synchronous clear.
// Carry is combinational so three digits can cascade in one cycle.
module contador_bcd
  import medidor_frecuencia_pkg::*;
(
  input  logic               clock,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  assign carry = inc && (digit == BCD_MAX);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else begin
      digit <= bcd_next(digit, inc);
    end
  end

endmodule

// File: rtl/medidor_frecuencia.sv
// Gated edge counter: counts sig_in rises over GATE_CYCLES
// clocks and reports the total as three saturating BCD digits.
module medidor_frecuencia
  import medidor_frecuencia_pkg::*;
#(
  parameter int GATE_CYCLES = 50000000
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               enable,
  output logic [DIGIT_W-1:0] centena,
  output logic [DIGIT_W-1:0] decena,
  output logic [DIGIT_W-1:0] unidad,
  output logic               valid,
  output logic               overflow
);

  localparam int CW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GATE_CYCLES - 1);

  logic s1, s2, s3;
  logic edge_pulse;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

  estado_t       state;
  logic [CW-1:0] gate_cnt;
  logic          ovf_flag;

  logic [DIGIT_W-1:0] acc_u, acc_d, acc_c;
  logic               cy_u, cy_d, carry_unused;
  logic               hit, at_max, inc_u, clr;
  logic [DIGIT_W-1:0] nxt_u, nxt_d, nxt_c;
  logic               ovf_next;

  assign hit    = edge_pulse && (state == GATE);
  assign at_max = (acc_u == BCD_MAX) &&
                  (acc_d == BCD_MAX) &&
                  (acc_c == BCD_MAX);
  assign inc_u  = hit && !at_max;
  assign clr    = (state == CLEAR);

  contador_bcd u_unidad (
    .clock (clock),
    .rst_n (rst_n),
    .clear (clr),
    .inc   (inc_u),
    .digit (acc_u),
    .carry (cy_u)
  );

  contador_bcd u_decena (
    .clock (clock),
    .rst_n (rst_n),
    .clear (clr),
    .inc   (cy_u),
    .digit (acc_d),
    .carry (cy_d)
  );

  contador_bcd u_centena (
    .clock (clock),
    .rst_n (rst_n),
    .clear (clr),
    .inc   (cy_d),
    .digit (acc_c),
    .carry (carry_unused)
  );

  // Latch the post-increment value so an edge on the
  // final gate cycle lands in this window.
  assign nxt_u    = bcd_next(acc_u, inc_u);
  assign nxt_d    = bcd_next(acc_d, cy_u);
  assign nxt_c    = bcd_next(acc_c, cy_d);
  assign ovf_next = ovf_flag | (hit & at_max);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      ovf_flag <= 1'b0;
      centena  <= '0;
      decena   <= '0;
      unidad   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) state <= CLEAR;
        end
        CLEAR: begin
          gate_cnt <= '0;
          ovf_flag <= 1'b0;
          state    <= GATE;
        end
        GATE: begin
          ovf_flag <= ovf_next;
          if (gate_cnt == LAST) begin
            state    <= LATCH;
            centena  <= nxt_c;
            decena   <= nxt_d;
            unidad   <= nxt_u;
            overflow <= ovf_next;
            valid    <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        LATCH: begin
          state <= enable ? CLEAR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_frecuencia.sv
// Directed bench for medidor_frecuencia: short and long
// gate windows, saturation, reset and enable scenarios.
module tb_medidor_frecuencia;
  import medidor_frecuencia_pkg::*;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       sig_s, en_s, sig_b, en_b;
  logic [3:0] c_s, d_s, u_s, c_b, d_b, u_b;
  logic       v_s, o_s, v_b, o_b;

  int checks   = 0;
  int failures = 0;
  int half_s   = 0;
  int gc_s     = 0;
  int half_b   = 0;
  int gc_b     = 0;

  always #5 clock = ~clock;

  medidor_frecuencia #(.GATE_CYCLES(100)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .sig_in   (sig_s),
    .enable   (en_s),
    .centena  (c_s),
    .decena   (d_s),
    .unidad   (u_s),
    .valid    (v_s),
    .overflow (o_s)
  );

  medidor_frecuencia #(.GATE_CYCLES(4000)) dut_big (
    .clock    (clock),
    .rst_n    (rst_n),
    .sig_in   (sig_b),
    .enable   (en_b),
    .centena  (c_b),
    .decena   (d_b),
    .unidad   (u_b),
    .valid    (v_b),
    .overflow (o_b)
  );

  task tick();
    @(negedge clock);
    if (half_s != 0) begin
      gc_s++;
      if (gc_s >= half_s) begin
        gc_s  = 0;
        sig_s = ~sig_s;
      end
    end
    if (half_b != 0) begin
      gc_b++;
      if (gc_b >= half_b) begin
        gc_b  = 0;
        sig_b = ~sig_b;
      end
    end
  endtask

  task automatic wait_valid(input bit big, input int budget,
                            output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      tick();
      n++;
      seen = big ? v_b : v_s;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_valid big=%0d no pulse in %0d cycles",
               big, budget);
      n = -1;
    end
  endtask

  task test_reset();
    rst_n  = 1'b0;
    en_s   = 1'b0;
    en_b   = 1'b0;
    sig_s  = 1'b0;
    sig_b  = 1'b0;
    half_s = 0;
    half_b = 0;
    repeat (3) tick();
    checks++;
    if ({c_s, d_s, u_s, v_s, o_s} !== 14'd0) begin
      failures++;
      $display("FAIL reset_small got %h%h%h v=%b o=%b want 000 0 0",
               c_s, d_s, u_s, v_s, o_s);
    end
    checks++;
    if ({c_b, d_b, u_b, v_b, o_b} !== 14'd0) begin
      failures++;
      $display("FAIL reset_big got %h%h%h v=%b o=%b want 000 0 0",
               c_b, d_b, u_b, v_b, o_b);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (dut.state !== IDLE || v_s !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got state=%0d v=%b want 0 0",
               dut.state, v_s);
    end
  endtask

  task test_periodic();
    int n;
    half_s = 5;
    gc_s   = 0;
    sig_s  = 1'b0;
    en_s   = 1'b1;
    wait_valid(1'b0, 200, n);
    checks++;
    if (n != 102 || {c_s, d_s, u_s} !== 12'h010 || o_s !== 1'b0) begin
      failures++;
      $display("FAIL first_window got n=%0d %h%h%h o=%b want 102 010 0",
               n, c_s, d_s, u_s, o_s);
    end
  endtask

  task test_back_to_back();
    int n;
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++;
      if (v_s !== 1'b0) begin
        failures++;
        $display("FAIL valid_width w=%0d got %b want 0", w, v_s);
      end
      wait_valid(1'b0, 200, n);
      checks++;
      if (n + 1 != 102 || {c_s, d_s, u_s} !== 12'h010 ||
          o_s !== 1'b0) begin
        failures++;
        $display("FAIL window w=%0d got n=%0d %h%h%h o=%b want 102 010 0",
                 w, n + 1, c_s, d_s, u_s, o_s);
      end
    end
  endtask

  task test_reset_mid();
    int n;
    repeat (55) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({c_s, d_s, u_s, v_s, o_s} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset got %h%h%h v=%b o=%b want 000 0 0",
               c_s, d_s, u_s, v_s, o_s);
    end
    sig_s = 1'b0;
    gc_s  = 0;
    tick();
    rst_n = 1'b1;
    wait_valid(1'b0, 200, n);
    checks++;
    if (n != 102 || {c_s, d_s, u_s} !== 12'h010) begin
      failures++;
      $display("FAIL after_reset got n=%0d %h%h%h want 102 010",
               n, c_s, d_s, u_s);
    end
  endtask

  task test_enable_drop();
    int n;
    bit extra;
    repeat (32) tick();
    en_s = 1'b0;
    wait_valid(1'b0, 200, n);
    checks++;
    if (n != 70 || {c_s, d_s, u_s} !== 12'h010) begin
      failures++;
      $display("FAIL drop_window got n=%0d %h%h%h want 70 010",
               n, c_s, d_s, u_s);
    end
    extra = 1'b0;
    repeat (300) begin
      tick();
      if (v_s) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0 || dut.state !== IDLE ||
        {c_s, d_s, u_s} !== 12'h010) begin
      failures++;
      $display("FAIL drop_idle got extra=%b state=%0d %h%h%h want 0 0 010",
               extra, dut.state, c_s, d_s, u_s);
    end
  endtask

  task test_constant();
    int n;
    half_s = 0;
    sig_s  = 1'b0;
    en_s   = 1'b1;
    wait_valid(1'b0, 200, n);
    checks++;
    if (n != 102 || {c_s, d_s, u_s, o_s} !== 13'd0) begin
      failures++;
      $display("FAIL const_low got n=%0d %h%h%h o=%b want 102 000 0",
               n, c_s, d_s, u_s, o_s);
    end
    sig_s = 1'b1;
    wait_valid(1'b0, 200, n);
    checks++;
    if ({c_s, d_s, u_s} !== 12'h001) begin
      failures++;
      $display("FAIL single_rise got %h%h%h want 001", c_s, d_s, u_s);
    end
    wait_valid(1'b0, 200, n);
    checks++;
    if (n != 102 || {c_s, d_s, u_s, o_s} !== 13'd0) begin
      failures++;
      $display("FAIL const_high got n=%0d %h%h%h o=%b want 102 000 0",
               n, c_s, d_s, u_s, o_s);
    end
  endtask

  task test_last_cycle();
    int n;
    sig_s = 1'b0;
    wait_valid(1'b0, 200, n);
    for (int j = 1; j <= 101; j++) begin
      tick();
      if (j % 10 == 9) sig_s = 1'b1;
      else if (j % 10 == 4) sig_s = 1'b0;
    end
    tick();
    checks++;
    if (v_s !== 1'b1 || {c_s, d_s, u_s} !== 12'h010) begin
      failures++;
      $display("FAIL last_cycle got v=%b %h%h%h want 1 010",
               v_s, c_s, d_s, u_s);
    end
  endtask

  task test_overflow();
    int n;
    en_s   = 1'b0;
    half_b = 1;
    gc_b   = 0;
    sig_b  = 1'b0;
    en_b   = 1'b1;
    wait_valid(1'b1, 4200, n);
    checks++;
    if (n != 4002 || {c_b, d_b, u_b} !== 12'h999 || o_b !== 1'b1) begin
      failures++;
      $display("FAIL saturate got n=%0d %h%h%h o=%b want 4002 999 1",
               n, c_b, d_b, u_b, o_b);
    end
    half_b = 20;
    gc_b   = 0;
    sig_b  = 1'b0;
    wait_valid(1'b1, 4200, n);
    checks++;
    if (n != 4002 || {c_b, d_b, u_b} !== 12'h100 || o_b !== 1'b0) begin
      failures++;
      $display("FAIL after_ovf got n=%0d %h%h%h o=%b want 4002 100 0",
               n, c_b, d_b, u_b, o_b);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_back_to_back();
    test_reset_mid();
    test_enable_drop();
    test_constant();
    test_last_cycle();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
